// File: rtl/dsss_pkg.sv
// dsss_pkg: constants and types shared by the DSSS transmitter and receiver
package dsss_pkg;
  localparam int CHIP_LEN = 16;
  localparam int SEQ_LEN = 31;
  localparam int CNT_W = $clog2(CHIP_LEN);
  localparam logic [4:0] LFSR_SEED = 5'b00110;
  localparam logic [1:0] IF_POS = 2'b01;
  localparam logic [1:0] IF_NEG = 2'b11;
  localparam logic [1:0] IF_ZERO = 2'b00;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/dsss_bpsk_mod_if.sv
// dsss_bpsk_mod_if: valid/ready data-bit stream into the transmitter
interface dsss_bpsk_mod_if;
  logic data_in;
  logic data_valid;
  logic data_ready;
  modport master(output data_in, output data_valid, input data_ready);
  modport slave(input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/dsss_bpsk_mod_mseq_gen.sv
// mseq_gen: 5-bit Fibonacci LFSR producing the 31-chip m-sequence
module mseq_gen
  import dsss_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic chip
);
  logic [4:0] lfsr;
  always_ff @(posedge clk)
    if (rst || load) lfsr <= LFSR_SEED;
    else if (step) lfsr <= {lfsr[3] ^ lfsr[0], lfsr[4:1]};
  assign chip = lfsr[0];
endmodule

// File: rtl/dsss_bpsk_mod.sv
// dsss_bpsk_mod: spreads each data bit over 31 chips, BPSK on an fs/4 carrier
module dsss_bpsk_mod
  import dsss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dsss_bpsk_mod_if.slave    s,
  output logic signed [1:0] IFout,
  output logic              chip_out,
  output logic              sym_start
);
  state_t           state;
  logic             d_reg;
  logic [1:0]       phase;
  logic [CNT_W-1:0] chip_cnt;
  logic [4:0]       chip_idx;
  logic             run, wrap, last, tr, chip, b;
  always_comb begin
    run  = state == RUN;
    wrap = chip_cnt == CNT_W'(CHIP_LEN - 1);
    last = run && wrap && chip_idx == 5'(SEQ_LEN - 1);
    tr   = s.data_valid && s.data_ready;
    b    = d_reg ^ chip;
  end
  assign s.data_ready = !rst && (!run || last);
  // a transfer reseeds the code; otherwise it advances once per chip
  mseq_gen u_mseq (
    .clk (clk),
    .rst (rst),
    .load(tr),
    .step(run && wrap && !tr),
    .chip(chip)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      d_reg     <= 1'b0;
      phase     <= '0;
      chip_cnt  <= '0;
      chip_idx  <= '0;
      IFout     <= IF_ZERO;
      chip_out  <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      IFout     <= (!run || phase[0]) ? IF_ZERO : (b ^ phase[1]) ? IF_POS : IF_NEG;
      chip_out  <= run && chip;
      sym_start <= run && phase == '0 && chip_cnt == '0 && chip_idx == '0;
      if (tr) begin
        state    <= RUN;
        d_reg    <= s.data_in;
        phase    <= '0;
        chip_cnt <= '0;
        chip_idx <= '0;
      end else if (run) begin
        state    <= last ? IDLE : RUN;
        phase    <= phase + 2'd1;
        chip_cnt <= chip_cnt + CNT_W'(1);
        chip_idx <= chip_idx + 5'(wrap);
      end
    end
endmodule

// File: tb/tb_dsss_bpsk_mod.sv
// tb_dsss_bpsk_mod: scoreboard bench, expected per-cycle outputs queued by the driver
module tb_dsss_bpsk_mod;
  logic clk = 1'b0;
  logic rst;
  logic signed [1:0] ifo;
  logic ch, ss;
  logic mon_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [4:0] q[$];
  logic [4:0] act, exp_v;
  logic [0:30] seq = 31'b0110001111100110100100001010111;

  always #5 clk = ~clk;

  dsss_bpsk_mod_if sif ();

  dsss_bpsk_mod dut (
    .clk      (clk),
    .rst      (rst),
    .s        (sif),
    .IFout    (ifo),
    .chip_out (ch),
    .sym_start(ss)
  );

  function automatic logic [4:0] samp(input logic dd, input int k, input logic r);
    int p, c;
    logic b;
    logic [1:0] v;
    p = (k - 1) % 4;
    c = (k - 1) / 16;
    b = dd ^ seq[c];
    v = (p % 2 == 1) ? 2'b00 : ((b ^ (p == 2)) ? 2'b01 : 2'b11);
    return {v, seq[c], k == 1, r};
  endfunction

  task automatic step(input logic r, input logic v, input logic d, input logic [4:0] e);
    rst = r;
    sif.data_valid = v;
    sif.data_in = d;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0, 5'b00001);
  endtask

  task automatic start(input logic d);
    step(1'b0, 1'b1, d, 5'b00001);
  endtask

  task automatic run_sym(input logic d, input logic first, input logic chained, input logic nd,
                         input int len);
    logic ab;
    if (first) step(1'b0, chained, nd, 5'b00000);
    for (int k = 1; k <= len; k++) begin
      ab = (k == len) && (len < 496);
      step(ab, chained, nd, samp(d, k, ab ? 1'b0 : (k == 495 || (k == 496 && !chained))));
    end
  endtask

  always @(negedge clk)
    if (mon_en) begin
      act = {ifo, ch, ss, sif.data_ready};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: got %b with nothing expected", n, act);
      end else begin
        exp_v = q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL sample cycle %0d: got IFout=%b chip=%b sym=%b rdy=%b, want IFout=%b chip=%b sym=%b rdy=%b",
                   n, act[4:3], act[2], act[1], act[0], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
      n++;
    end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sif.data_valid = 1'b1;
    sif.data_in = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 5'b00000);
    step(1'b1, 1'b1, 1'b1, 5'b00000);
    step(1'b0, 1'b0, 1'b0, 5'b00001);
    idle(3);
    start(1'b0);
    run_sym(1'b0, 1'b1, 1'b0, 1'b0, 496);
    idle(2);
    start(1'b1);
    run_sym(1'b1, 1'b1, 1'b0, 1'b0, 496);
    idle(2);
    start(1'b1);
    run_sym(1'b1, 1'b1, 1'b1, 1'b0, 496);
    run_sym(1'b0, 1'b0, 1'b1, 1'b1, 496);
    run_sym(1'b1, 1'b0, 1'b0, 1'b0, 496);
    idle(2);
    start(1'b1);
    run_sym(1'b1, 1'b1, 1'b0, 1'b0, 496);
    idle(18);
    start(1'b0);
    run_sym(1'b0, 1'b1, 1'b0, 1'b0, 496);
    idle(2);
    start(1'b0);
    run_sym(1'b0, 1'b1, 1'b0, 1'b0, 200);
    idle(2);
    start(1'b0);
    run_sym(1'b0, 1'b1, 1'b0, 1'b0, 496);
    idle(3);
    mon_en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unconsumed entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsss_bpsk_mod.md
# dsss_bpsk_mod

Synthesizable DSSS/BPSK transmitter producing the 2-bit signed IF sample stream consumed by the despreading receiver `top`. Each accepted data bit D is XORed with a 31-chip m-sequence. Each chip lasts 16 clocks and is BPSK-mapped onto an fs/4 cosine carrier (1, 0, −1, 0). It sits directly upstream of the receiver and replaces the behavioural stimulus, giving an RTL loopback path.

## Interface
- `CHIP_LEN`, 16, clocks per chip (power of two).
- `SEQ_LEN`, 31, chips per data bit; one symbol = CHIP_LEN·SEQ_LEN = 496 clocks.
- `LFSR_SEED`, 5'b00110, m-sequence register value at the start of every symbol.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  1  data bit D.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block accepts `data_in` on this edge.
- `IFout`  out  2 signed  IF sample: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0.
- `chip_out`  out  1  m-chip in effect for the current `IFout` sample.
- `sym_start`  out  1  one-cycle pulse aligned with the first sample of each symbol.

## Operation
- FSM with two states.
  - IDLE: `IFout` is 0 and `data_ready` is 1.
  - RUN: one symbol is being emitted.
- Handshake: a transfer occurs on an edge where `data_valid & data_ready`. The bit is latched into `d_reg`. On the same edge, state goes to RUN, `phase` = 0, `chip_cnt` = 0, `chip_idx` = 0, `lfsr` = `LFSR_SEED`.
- `data_ready` = !rst & (IDLE | (RUN & chip_idx == SEQ_LEN−1 & chip_cnt == CHIP_LEN−1)). It is combinational from state.
- Counters advance every RUN cycle:
  - `phase` (2 bits) wraps 3→0.
  - `chip_cnt` wraps CHIP_LEN−1→0.
  - On that wrap, `chip_idx` increments and `lfsr` steps: lfsr ← {lfsr[3]^lfsr[0], lfsr[4:1]}.
  - The chip is lfsr[0]. The sequence from the seed starts 0, 1, 1, 0, … and has period 31.
- End of symbol, on the last cycle of chip 30:
  - If a transfer occurs, the next symbol starts seamlessly: counters and lfsr are reloaded, with no gap sample.
  - Otherwise the FSM goes to IDLE.
- Mapping: b = d_reg ^ chip.
  - phase 0: b ? +1 : −1.
  - phase 2: b ? −1 : +1.
  - phase 1 and 3: 0.
- Width: `IFout` is only ever 2'b01, 2'b11 or 2'b00. 2'b10 is illegal.
- Reset mid-symbol aborts immediately. The partial bit is discarded and no held data survives.

## Timing
- Reset values:
  - `IFout` = 0, `chip_out` = 0, `sym_start` = 0.
  - State is IDLE. Counters and `d_reg` are 0. `lfsr` = `LFSR_SEED`.
  - `data_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- `IFout`, `chip_out` and `sym_start` are registered from the current state. Latency: transfer on edge E0 → first sample (phase 0, chip 0) is visible after edge E0+1.
- Samples of a symbol occupy edges E0+1 … E0+496.
- Back-to-back bits: `data_ready` is high for exactly 1 cycle per 496. `sym_start` pulses every 496 cycles, and `IFout` is continuous with the carrier phase unbroken.
- Starvation: with no transfer at the boundary, `IFout` = 0 from edge E0+497 until the next transfer. A restart always begins at phase 0 with `LFSR_SEED`.
- `data_valid` may drop without a transfer. A bit is held only by a completed transfer.

## Structure
- Package `dsss_pkg`, shared with the receiver, holds:
  - `CHIP_LEN`, `SEQ_LEN`, `LFSR_SEED`.
  - Constants `IF_POS` = 2'b01, `IF_NEG` = 2'b11, `IF_ZERO` = 2'b00.
  - The state enum.
- One sub-module, `mseq_gen`: 5-bit LFSR with `load` (to seed) and `step` inputs and `chip` output. The receiver's local code generator reuses it.
- The top level holds the FSM, counters and output registers.

## Test plan
- Reset: hold `rst` for 3 cycles with `data_valid` = 1 → `IFout` = 0, `data_ready` = 0 during reset. After release `data_ready` = 1, and no transfer happened while `rst` was high.
- Single bit D = 0:
  - Samples 1–16 (chip 0) repeat −1, 0, +1, 0.
  - Samples 17–48 (chips 1, 2) repeat +1, 0, −1, 0.
  - `sym_start` is high only on sample 1.
  - `IFout` = 0 from sample 497.
- Single bit D = 1 → every sample is negated versus D = 0. `chip_out` over 31 chips matches `mseq_gen`, with 16 ones and 15 zeros.
- Bits 1, 0, 1 with `data_valid` held high → three contiguous 496-sample symbols with no zero gap. `data_ready` pulses exactly once per symbol, on the last cycle of chip 30. `sym_start` fires at samples 1, 497 and 993.
- Starvation: drop `data_valid` for 20 cycles after symbol 1, then send D = 0 → 20 zero samples after sample 496, then the D = 0 pattern restarts at phase 0, chip 0.
- Reset mid-symbol: assert `rst` at sample 200 for 1 cycle → `IFout` = 0 on the next edge and the FSM is IDLE. A new transfer reproduces the exact D pattern from sample 1.
